// File: rtl/mux_sel_arbiter_if.sv
// Two-source to one-sink word bus for mux_sel_arbiter, plus its status outputs.
// The sources and the sink sit on the master side, and the arbiter sits on the slave side.
interface mux_sel_arbiter_if #(parameter int WIDTH = 8);
   logic             i1_valid;
   logic [WIDTH-1:0] i1_data;
   logic             i1_ready;
   logic             i2_valid;
   logic [WIDTH-1:0] i2_data;
   logic             i2_ready;
   logic             y_valid;
   logic [WIDTH-1:0] y_data;
   logic             y_ready;
   logic             s0;
   logic [15:0]      xfer_cnt;

   modport master (
      output i1_valid, i1_data, i2_valid, i2_data, y_ready,
      input  i1_ready, i2_ready, y_valid, y_data, s0, xfer_cnt
   );

   modport slave (
      input  i1_valid, i1_data, i2_valid, i2_data, y_ready,
      output i1_ready, i2_ready, y_valid, y_data, s0, xfer_cnt
   );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin 2:1 word arbiter with a single registered output stage.
// Ties alternate between sources. The output reloads in the same cycle it is popped.
module mux_sel_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   mux_sel_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] HOLD0 = 2'd1;
   localparam logic [1:0] HOLD1 = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] y_data_q;
   logic             s0_q;
   logic             last_win;
   logic [15:0]      cnt;

   logic             y_valid;
   logic             free;
   logic             grant1;
   logic             grant2;
   logic             accept;
   logic [WIDTH-1:0] win_data;

   assign y_valid = (state != IDLE);
   assign free    = ~y_valid | bus.y_ready;

   // On a tie, the source that did not win last time gets the grant.
   // last_win resets to 1 so that i1 wins the first tie.
   always_comb begin
      grant1 = 1'b0;
      grant2 = 1'b0;
      if (free && !rst) begin
         if (bus.i1_valid && (!bus.i2_valid || last_win))
            grant1 = 1'b1;
         else if (bus.i2_valid)
            grant2 = 1'b1;
      end
   end

   assign accept   = grant1 | grant2;
   assign win_data = grant2 ? bus.i2_data : bus.i1_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         y_data_q <= '0;
         s0_q     <= 1'b0;
         last_win <= 1'b1;
         cnt      <= 16'd0;
      end else if (accept) begin
         y_data_q <= win_data;
         s0_q     <= grant2;
         last_win <= grant2;
         state    <= grant2 ? HOLD1 : HOLD0;
         cnt      <= cnt + 16'd1;
      end else if (free) begin
         // When the register is drained and nothing arrives, the data and source stay as they were.
         state <= IDLE;
      end
   end

   assign bus.i1_ready = grant1;
   assign bus.i2_ready = grant2;
   assign bus.y_valid  = y_valid;
   assign bus.y_data   = y_data_q;
   assign bus.s0       = s0_q;
   assign bus.xfer_cnt = cnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter. A vector table covers the steady-state behaviour.
// Hand sequences cover asynchronous reset and counter wrap.
module tb_mux_sel_arbiter;

   typedef struct {
      logic       i1v;
      logic [7:0] i1d;
      logic       i2v;
      logic [7:0] i2d;
      logic       yr;
      logic       e_r1;
      logic       e_r2;
      logic       e_yv;
      logic [7:0] e_yd;
      logic       e_s0;
      logic [15:0] e_cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t vq[$];

   mux_sel_arbiter_if #(.WIDTH(8)) bus ();

   mux_sel_arbiter #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic i1v, input logic [7:0] i1d, input logic i2v, input logic [7:0] i2d,
                      input logic yr, input logic r1, input logic r2, input logic yv,
                      input logic [7:0] yd, input logic s0, input logic [15:0] cnt);
      vec_t v;
      v.i1v = i1v; v.i1d = i1d; v.i2v = i2v; v.i2d = i2d; v.yr = yr;
      v.e_r1 = r1; v.e_r2 = r2; v.e_yv = yv; v.e_yd = yd; v.e_s0 = s0; v.e_cnt = cnt;
      vq.push_back(v);
   endtask

   task automatic drive(input logic i1v, input logic [7:0] i1d, input logic i2v, input logic [7:0] i2d,
                        input logic yr);
      bus.i1_valid = i1v;
      bus.i1_data  = i1d;
      bus.i2_valid = i2v;
      bus.i2_data  = i2d;
      bus.y_ready  = yr;
   endtask

   task automatic chk_out(input string tag, input logic yv, input logic [7:0] yd, input logic s0,
                          input logic [15:0] cnt);
      chk({tag, ".y_valid"},  16'(bus.y_valid), 16'(yv));
      chk({tag, ".y_data"},   16'(bus.y_data),  16'(yd));
      chk({tag, ".s0"},       16'(bus.s0),      16'(s0));
      chk({tag, ".xfer_cnt"}, bus.xfer_cnt,     cnt);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      drive(1'b1, 8'hFF, 1'b1, 8'hEE, 1'b1);
      rst = 1'b0;
      #1 rst = 1'b1;

      // i1 first (A5), i2 alone (44), then an alternating tie.
      add(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0,  1'b1, 8'hA5, 1'b0, 16'd1);
      add(1'b0, 8'h00, 1'b1, 8'h44, 1'b1,  1'b0, 1'b1,  1'b1, 8'h44, 1'b1, 16'd2);
      add(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,  1'b1, 1'b0,  1'b1, 8'h11, 1'b0, 16'd3);
      add(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,  1'b0, 1'b1,  1'b1, 8'h22, 1'b1, 16'd4);
      add(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,  1'b1, 1'b0,  1'b1, 8'h11, 1'b0, 16'd5);
      add(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,  1'b0, 1'b1,  1'b1, 8'h22, 1'b1, 16'd6);
      add(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,  1'b1, 1'b0,  1'b1, 8'h11, 1'b0, 16'd7);
      add(1'b1, 8'h11, 1'b1, 8'h22, 1'b1,  1'b0, 1'b1,  1'b1, 8'h22, 1'b1, 16'd8);
      // Sources go idle, so the output drains and keeps its last data.
      add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0,  1'b0, 8'h22, 1'b1, 16'd8);
      add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0,  1'b0, 8'h22, 1'b1, 16'd8);
      // 33 from i2 is loaded while idle, then held under backpressure.
      add(1'b0, 8'h00, 1'b1, 8'h33, 1'b0,  1'b0, 1'b1,  1'b1, 8'h33, 1'b1, 16'd9);
      add(1'b1, 8'h55, 1'b1, 8'h66, 1'b0,  1'b0, 1'b0,  1'b1, 8'h33, 1'b1, 16'd9);
      add(1'b1, 8'h55, 1'b1, 8'h66, 1'b0,  1'b0, 1'b0,  1'b1, 8'h33, 1'b1, 16'd9);
      add(1'b1, 8'h55, 1'b1, 8'h66, 1'b0,  1'b0, 1'b0,  1'b1, 8'h33, 1'b1, 16'd9);
      add(1'b1, 8'h55, 1'b1, 8'h66, 1'b0,  1'b0, 1'b0,  1'b1, 8'h33, 1'b1, 16'd9);
      add(1'b1, 8'h55, 1'b1, 8'h66, 1'b1,  1'b1, 1'b0,  1'b1, 8'h55, 1'b0, 16'd10);
      add(1'b1, 8'h55, 1'b1, 8'h66, 1'b1,  1'b0, 1'b1,  1'b1, 8'h66, 1'b1, 16'd11);
      // i2 drops while stalled, which is harmless. Then i1 alone, then a tie that goes to i2.
      add(1'b1, 8'h77, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0,  1'b1, 8'h66, 1'b1, 16'd11);
      add(1'b1, 8'h77, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0,  1'b1, 8'h77, 1'b0, 16'd12);
      add(1'b1, 8'h88, 1'b1, 8'h99, 1'b1,  1'b0, 1'b1,  1'b1, 8'h99, 1'b1, 16'd13);
      add(1'b0, 8'h00, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0,  1'b0, 8'h99, 1'b1, 16'd13);

      // Reset state, with both sources requesting.
      #1;
      chk_out("rst", 1'b0, 8'h00, 1'b0, 16'd0);
      chk("rst.i1_ready", 16'(bus.i1_ready), 16'd0);
      chk("rst.i2_ready", 16'(bus.i2_ready), 16'd0);
      @(posedge clk);
      #1;
      chk("rst_clk.i1_ready", 16'(bus.i1_ready), 16'd0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vq[i]) begin
         drive(vq[i].i1v, vq[i].i1d, vq[i].i2v, vq[i].i2d, vq[i].yr);
         #1;
         chk($sformatf("v%0d.i1_ready", i), 16'(bus.i1_ready), 16'(vq[i].e_r1));
         chk($sformatf("v%0d.i2_ready", i), 16'(bus.i2_ready), 16'(vq[i].e_r2));
         @(posedge clk);
         #1;
         chk_out($sformatf("v%0d", i), vq[i].e_yv, vq[i].e_yd, vq[i].e_s0, vq[i].e_cnt);
      end

      // Asynchronous reset between edges while a word is held.
      drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      chk_out("pre_arst", 1'b1, 8'h12, 1'b0, 16'd14);
      #2 rst = 1'b1;
      #1;
      chk_out("arst", 1'b0, 8'h00, 1'b0, 16'd0);
      chk("arst.i1_ready", 16'(bus.i1_ready), 16'd0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 8'hAB, 1'b1, 8'hCD, 1'b1);
      #1;
      chk("post_arst.i1_ready", 16'(bus.i1_ready), 16'd1);
      chk("post_arst.i2_ready", 16'(bus.i2_ready), 16'd0);
      @(posedge clk);
      #1;
      chk_out("post_arst", 1'b1, 8'hAB, 1'b0, 16'd1);

      // Counter wrap: i1 streams one word per cycle until the count reaches FFFF, and then one more word.
      drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      repeat (65534) @(posedge clk);
      #1;
      chk("wrap.ffff", bus.xfer_cnt, 16'hFFFF);
      @(posedge clk);
      #1;
      chk_out("wrap.zero", 1'b1, 8'h5A, 1'b0, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both sources and the output.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 i1_valid  input  1  source 0 has a word on i1_data.
REQ-005 i1_data  input  WIDTH  source 0 data.
REQ-006 i1_ready  output  1  source 0 word accepted this cycle when high together with i1_valid.
REQ-007 i2_valid  input  1  source 1 has a word on i2_data.
REQ-008 i2_data  input  WIDTH  source 1 data.
REQ-009 i2_ready  output  1  source 1 word accepted this cycle when high together with i2_valid.
REQ-010 y_valid  output  1  y_data holds a valid word.
REQ-011 y_data  output  WIDTH  registered selected word.
REQ-012 y_ready  input  1  consumer takes y_data this cycle when high together with y_valid.
REQ-013 s0  output  1  registered source of the word in y_data: 0 = i1, 1 = i2.
REQ-014 xfer_cnt  output  16  count of words accepted from either source.

Function
REQ-015 free = ~y_valid | y_ready: the output register can load this cycle.
REQ-016 The FSM shall have three states: IDLE (y_valid=0), HOLD0 (word from i1 held), HOLD1 (word from i2 held).
REQ-017 Winner selection when free: only i1_valid -> i1; only i2_valid -> i2; both -> the source other than last_win (round robin); neither -> no winner.
REQ-018 i1_ready and i2_ready shall be combinational; only the winner's ready is high, and both are low when free=0.
REQ-019 On accept, next edge: y_data <= winner data, s0 <= winner index, last_win <= winner index, y_valid <= 1, state <= HOLD0/HOLD1.
REQ-020 If free and no winner, y_valid shall go 0 and state shall go to IDLE at the next edge; y_data and s0 shall hold their values.
REQ-021 If y_valid=1 and y_ready=0, y_data, s0 and state shall hold; both readies shall be low (backpressure).
REQ-022 Pop and load in the same cycle (y_ready=1 with a winner) shall sustain 1 word per cycle with no bubble.
REQ-023 Latency: accept at edge N -> y_valid=1 with that word after edge N.
REQ-024 xfer_cnt shall increment by 1 per accepted word and wrap from 16'hFFFF to 0.
REQ-025 A source's valid dropping while it is not granted shall have no effect; no word is lost or duplicated.
REQ-026 Under continuous dual requests with y_ready=1, grants shall alternate strictly i1, i2, i1, ...

Reset
REQ-027 While reset=1, regardless of clock: y_valid=0, y_data=0, s0=0, xfer_cnt=0, state=IDLE, last_win=1 (i1 wins the first tie).
REQ-028 Both readies shall be 0 while reset=1.
REQ-029 Reset asserted mid-transfer shall discard the held word; after release the block shall behave as from power-up.

Verification
REQ-030 Reset, then i1_valid=1, i1_data=8'hA5, y_ready=1 for 1 cycle -> i1_ready=1; next cycle y_valid=1, y_data=8'hA5, s0=0, xfer_cnt=1.
REQ-031 Both valid continuously (i1=8'h11, i2=8'h22), y_ready=1 for 6 cycles -> y_data sequence 11,22,11,22,11,22; s0 = 0,1,0,1,0,1.
REQ-032 Word 8'h33 from i2 held, y_ready=0 for 4 cycles with both sources valid -> y_data stays 8'h33, s0=1, i1_ready=i2_ready=0; y_ready=1 then loads i1's word, no bubble.
REQ-033 Preload xfer_cnt to 16'hFFFF via 65535 transfers, one more accept -> xfer_cnt=0.
REQ-034 reset pulsed asynchronously between edges while y_valid=1 -> y_valid, y_data, s0, xfer_cnt = 0 immediately; the first tie after release goes to i1.
REQ-035 Sources idle with y_ready=1 after one word -> y_valid drops to 0 the following cycle; y_data retains its last value.
